// File: rtl/id_stage_hs.sv
// Decode stage between IF and EX: valid/ready on both sides, read-port enable held until its strobe.
// Define ID_FORWARD_EN to let a matching writeback complete a pending read port.
`ifndef OP_R_TYPE
`define OP_NOP    6'h00
`define OP_R_TYPE 6'h01
`define OP_I_TYPE 6'h02
`define OP_LW     6'h03
`define OP_LH     6'h04
`define OP_LD     6'h05
`define OP_BR     6'h06
`define OP_SD     6'h07
`define OP_SH     6'h08
`define OP_SW     6'h09
`define OP_J_TYPE 6'h0A
`define OP_HALT   6'h3F
`endif
`ifndef NOP
`define NOP 32'h0000_0000
`endif

module id_stage_hs #(
  parameter int DATA_W       = 32,
  parameter int REG_ADDR_LEN = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             ir_in,
  input  logic [DATA_W-3:0]       pc_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             ir_out,
  output logic [DATA_W-3:0]       pc_out,
  output logic [DATA_W-1:0]       x_out,
  output logic [DATA_W-1:0]       y_out,
  output logic [REG_ADDR_LEN-1:0] rd1_addr,
  output logic [REG_ADDR_LEN-1:0] rd2_addr,
  output logic                    rd1_en,
  output logic                    rd2_en,
  input  logic [DATA_W-1:0]       rd1_data,
  input  logic [DATA_W-1:0]       rd2_data,
  input  logic                    rd1_st,
  input  logic                    rd2_st,
  input  logic                    flush
`ifdef ID_FORWARD_EN
  ,
  input  logic                    wb_en,
  input  logic [REG_ADDR_LEN-1:0] wb_addr,
  input  logic [DATA_W-1:0]       wb_data
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t                  state_q, state_d;
  logic [31:0]             ir_q, ir_d;
  logic [DATA_W-3:0]       pc_q, pc_d;
  logic [DATA_W-1:0]       x_q, x_d, y_q, y_d;
  logic [REG_ADDR_LEN-1:0] rd1_addr_q, rd1_addr_d, rd2_addr_q, rd2_addr_d;
  logic                    rd1_en_q, rd1_en_d, rd2_en_q, rd2_en_d;

  logic                    accept, hit1, hit2;
  logic [DATA_W-1:0]       cap1, cap2, imm_sext, tgt_zext;
  logic [5:0]              opc;
  logic [REG_ADDR_LEN-1:0] f_rd, f_rs, f_rt;

  assign opc      = ir_in[31:26];
  assign f_rd     = REG_ADDR_LEN'(ir_in[25:21]);
  assign f_rs     = REG_ADDR_LEN'(ir_in[20:16]);
  assign f_rt     = REG_ADDR_LEN'(ir_in[15:11]);
  assign imm_sext = {{(DATA_W-16){ir_in[15]}}, ir_in[15:0]};
  assign tgt_zext = DATA_W'(ir_in[25:0]);

  assign in_ready = !flush && (state_q == IDLE || (state_q == DONE && out_ready));
  assign accept   = in_valid && in_ready;

`ifdef ID_FORWARD_EN
  logic fwd1, fwd2;
  assign fwd1 = wb_en && (wb_addr == rd1_addr_q);
  assign fwd2 = wb_en && (wb_addr == rd2_addr_q);
  assign hit1 = (state_q == REQ) && rd1_en_q && (rd1_st || fwd1);
  assign hit2 = (state_q == REQ) && rd2_en_q && (rd2_st || fwd2);
  assign cap1 = fwd1 ? wb_data : rd1_data;
  assign cap2 = fwd2 ? wb_data : rd2_data;
`else
  assign hit1 = (state_q == REQ) && rd1_en_q && rd1_st;
  assign hit2 = (state_q == REQ) && rd2_en_q && rd2_st;
  assign cap1 = rd1_data;
  assign cap2 = rd2_data;
`endif

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    pc_d       = pc_q;
    x_d        = x_q;
    y_d        = y_q;
    rd1_addr_d = rd1_addr_q;
    rd2_addr_d = rd2_addr_q;
    rd1_en_d   = rd1_en_q;
    rd2_en_d   = rd2_en_q;
    if (flush) begin
      state_d  = IDLE;
      rd1_en_d = 1'b0;
      rd2_en_d = 1'b0;
      ir_d     = `NOP;
    end else begin
      if (state_q == REQ) begin
        if (hit1) begin
          x_d      = cap1;
          rd1_en_d = 1'b0;
        end
        if (hit2) begin
          y_d      = cap2;
          rd2_en_d = 1'b0;
        end
        if (!rd1_en_d && !rd2_en_d) state_d = DONE;
      end
      if (state_q == DONE && out_ready) state_d = IDLE;
      // Accept only happens in IDLE/DONE, where both enables are already low.
      if (accept) begin
        ir_d = ir_in;
        pc_d = pc_in;
        case (opc)
          `OP_R_TYPE: begin
            rd1_addr_d = f_rs; rd2_addr_d = f_rt; rd1_en_d = 1'b1; rd2_en_d = 1'b1;
          end
          `OP_I_TYPE, `OP_LW, `OP_LH, `OP_LD: begin
            rd1_addr_d = f_rs; rd1_en_d = 1'b1; y_d = imm_sext;
          end
          `OP_BR: begin
            rd1_addr_d = f_rd; rd1_en_d = 1'b1; y_d = imm_sext;
          end
          `OP_SD, `OP_SH, `OP_SW: begin
            rd1_addr_d = f_rd; rd2_addr_d = f_rs; rd1_en_d = 1'b1; rd2_en_d = 1'b1;
          end
          `OP_J_TYPE: x_d = tgt_zext;
          default: ;
        endcase
        state_d = (rd1_en_d || rd2_en_d) ? REQ : DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ir_q       <= `NOP;
      pc_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      rd1_addr_q <= '0;
      rd2_addr_q <= '0;
      rd1_en_q   <= 1'b0;
      rd2_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      x_q        <= x_d;
      y_q        <= y_d;
      rd1_addr_q <= rd1_addr_d;
      rd2_addr_q <= rd2_addr_d;
      rd1_en_q   <= rd1_en_d;
      rd2_en_q   <= rd2_en_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign ir_out    = ir_q;
  assign pc_out    = pc_q;
  assign x_out     = x_q;
  assign y_out     = y_q;
  assign rd1_addr  = rd1_addr_q;
  assign rd2_addr  = rd2_addr_q;
  assign rd1_en    = rd1_en_q;
  assign rd2_en    = rd2_en_q;

endmodule

// File: tb/tb_id_stage_hs.sv
// Bench for id_stage_hs: directed scenarios plus random instruction stream against a decode model.
module tb_id_stage_hs;
  localparam int DATA_W = 32;
  localparam int RAL    = 5;
  localparam logic [5:0] OP_NOP = 6'h00, OP_R = 6'h01, OP_I = 6'h02, OP_LW = 6'h03, OP_LH = 6'h04,
                         OP_LD = 6'h05, OP_BR = 6'h06, OP_SD = 6'h07, OP_SH = 6'h08, OP_SW = 6'h09,
                         OP_J = 6'h0A, OP_HALT = 6'h3F, OP_UND = 6'h20;
  localparam logic [31:0] NOP_IR = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, flush = 1'b0;
  logic [31:0] ir_in = '0, ir_out;
  logic [DATA_W-3:0] pc_in = '0, pc_out;
  logic [DATA_W-1:0] x_out, y_out, rd1_data = '0, rd2_data = '0;
  logic [RAL-1:0] rd1_addr, rd2_addr;
  logic rd1_en, rd2_en, rd1_st = 1'b0, rd2_st = 1'b0;
`ifdef ID_FORWARD_EN
  logic wb_en = 1'b0;
  logic [RAL-1:0] wb_addr = '0;
  logic [DATA_W-1:0] wb_data = '0;
`endif

  int total = 0;
  int bad = 0;
  logic [DATA_W-1:0] regs [32];
  logic [DATA_W-1:0] exp_x = '0, exp_y = '0;

  typedef struct packed {
    logic n1, n2, set_x, set_y;
    logic [4:0] a1, a2;
    logic [31:0] vx, vy;
  } dec_t;

  id_stage_hs #(.DATA_W(DATA_W), .REG_ADDR_LEN(RAL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ir_in(ir_in), .pc_in(pc_in),
    .out_valid(out_valid), .out_ready(out_ready), .ir_out(ir_out), .pc_out(pc_out),
    .x_out(x_out), .y_out(y_out), .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .rd1_en(rd1_en), .rd2_en(rd2_en), .rd1_data(rd1_data), .rd2_data(rd2_data),
    .rd1_st(rd1_st), .rd2_st(rd2_st), .flush(flush)
`ifdef ID_FORWARD_EN
    , .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] f25, input logic [4:0] f20,
                                     input logic [15:0] lo);
    return {op, f25, f20, lo};
  endfunction

  // What the instruction asks for, straight from the field/opcode rules.
  function automatic dec_t decode(input logic [31:0] ir);
    dec_t d;
    logic [31:0] simm;
    d = '0;
    simm = {{16{ir[15]}}, ir[15:0]};
    case (ir[31:26])
      OP_R: begin d.n1 = 1; d.a1 = ir[20:16]; d.n2 = 1; d.a2 = ir[15:11]; end
      OP_I, OP_LW, OP_LH, OP_LD: begin d.n1 = 1; d.a1 = ir[20:16]; d.set_y = 1; d.vy = simm; end
      OP_BR: begin d.n1 = 1; d.a1 = ir[25:21]; d.set_y = 1; d.vy = simm; end
      OP_SD, OP_SH, OP_SW: begin d.n1 = 1; d.a1 = ir[25:21]; d.n2 = 1; d.a2 = ir[20:16]; end
      OP_J: begin d.set_x = 1; d.vx = {6'd0, ir[25:0]}; end
      default: ;
    endcase
    return d;
  endfunction

  task automatic run_txn(input logic [31:0] ir, input logic [29:0] pc, input int hold);
    dec_t d;
    logic p1, p2, s1, s2;
    int cyc;
    d = decode(ir);
    in_valid = 1; ir_in = ir; pc_in = pc; out_ready = 0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL txn_in_ready ir=%h got=%b want=1", ir, in_ready); end
    tick();
    in_valid = 0;
    if (d.set_x) exp_x = d.vx;
    if (d.set_y) exp_y = d.vy;
    p1 = d.n1; p2 = d.n2; cyc = 0;
    while ((p1 || p2) && cyc < 40) begin
      total++;
      if (rd1_en !== p1 || rd2_en !== p2 || out_valid !== 1'b0) begin
        bad++; $display("FAIL txn_req ir=%h en=%b%b ov=%b want en=%b%b ov=0", ir, rd1_en, rd2_en, out_valid, p1, p2);
      end
      if (p1) begin
        total++; if (rd1_addr !== d.a1) begin bad++; $display("FAIL txn_rd1_addr ir=%h got=%0d want=%0d", ir, rd1_addr, d.a1); end
      end
      if (p2) begin
        total++; if (rd2_addr !== d.a2) begin bad++; $display("FAIL txn_rd2_addr ir=%h got=%0d want=%0d", ir, rd2_addr, d.a2); end
      end
      s1 = ($urandom_range(0, 2) == 0);
      s2 = ($urandom_range(0, 2) == 0);
      rd1_st = s1; rd2_st = s2;
      rd1_data = p1 ? regs[rd1_addr] : $urandom;
      rd2_data = p2 ? regs[rd2_addr] : $urandom;
      tick();
      if (p1 && s1) begin exp_x = regs[d.a1]; p1 = 0; end
      if (p2 && s2) begin exp_y = regs[d.a2]; p2 = 0; end
      rd1_st = 0; rd2_st = 0;
      cyc++;
    end
    if (p1 || p2) begin total++; bad++; $display("FAIL txn_timeout ir=%h pending=%b%b want=00", ir, p1, p2); end
    for (int h = 0; h <= hold; h++) begin
      in_valid = (h < hold); ir_in = mk(OP_J, 5'd9, 5'd9, 16'h9);
      #1;
      total++;
      if (out_valid !== 1'b1 || ir_out !== ir || pc_out !== pc || x_out !== exp_x || y_out !== exp_y ||
          rd1_en !== 1'b0 || rd2_en !== 1'b0) begin
        bad++;
        $display("FAIL txn_done ir=%h got ov=%b ir=%h pc=%h x=%h y=%h en=%b%b want ov=1 ir=%h pc=%h x=%h y=%h en=00",
                 ir, out_valid, ir_out, pc_out, x_out, y_out, rd1_en, rd2_en, ir, pc, exp_x, exp_y);
      end
      if (h < hold) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL txn_hold_in_ready got=%b want=0", in_ready); end
        tick();
      end
    end
    in_valid = 0; out_ready = 1;
    tick();
    out_ready = 0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL txn_release ov got=%b want=0", out_valid); end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (out_valid !== 0 || rd1_en !== 0 || rd2_en !== 0 || x_out !== 0 || y_out !== 0 || pc_out !== 0 ||
        rd1_addr !== 0 || rd2_addr !== 0) begin
      bad++; $display("FAIL reset_outputs ov=%b en=%b%b x=%h y=%h pc=%h a=%0d/%0d want all 0",
                      out_valid, rd1_en, rd2_en, x_out, y_out, pc_out, rd1_addr, rd2_addr);
    end
    total++; if (ir_out !== NOP_IR) begin bad++; $display("FAIL reset_ir got=%h want=%h", ir_out, NOP_IR); end
    tick(); tick();
    rst = 0;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_rtype_latency();
    in_valid = 1; ir_in = mk(OP_R, 5'd0, 5'd1, {5'd2, 11'd0}); pc_in = 30'h100;
    tick();
    in_valid = 0;
    total++; if (rd1_en !== 1 || rd2_en !== 1 || rd1_addr !== 1 || rd2_addr !== 2 || out_valid !== 0) begin
      bad++; $display("FAIL rtype_req en=%b%b a=%0d/%0d ov=%b want en=11 a=1/2 ov=0", rd1_en, rd2_en, rd1_addr, rd2_addr, out_valid);
    end
    tick();
    rd1_st = 1; rd1_data = 32'h11;
    tick();
    rd1_st = 0;
    total++; if (rd1_en !== 0 || rd2_en !== 1 || out_valid !== 0) begin
      bad++; $display("FAIL rtype_rd1_first en=%b%b ov=%b want en=01 ov=0", rd1_en, rd2_en, out_valid);
    end
    tick(); tick();
    rd2_st = 1; rd2_data = 32'h22;
    tick();
    rd2_st = 0;
    total++; if (out_valid !== 1 || x_out !== 32'h11 || y_out !== 32'h22 || rd2_en !== 0) begin
      bad++; $display("FAIL rtype_done ov=%b x=%h y=%h en2=%b want ov=1 x=11 y=22 en2=0", out_valid, x_out, y_out, rd2_en);
    end
    exp_x = 32'h11; exp_y = 32'h22;
    out_ready = 1; tick(); out_ready = 0;
    total++; if (out_valid !== 0) begin bad++; $display("FAIL rtype_release ov got=%b want=0", out_valid); end
  endtask

  task automatic test_lw_hold();
    in_valid = 1; ir_in = mk(OP_LW, 5'd0, 5'd4, 16'hFFF0); pc_in = 30'h104;
    tick();
    in_valid = 0;
    total++; if (rd1_en !== 1 || rd2_en !== 0 || rd1_addr !== 4) begin
      bad++; $display("FAIL lw_req en=%b%b a1=%0d want en=10 a1=4", rd1_en, rd2_en, rd1_addr);
    end
    rd1_st = 1; rd1_data = 32'h100;
    tick();
    rd1_st = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; ir_in = mk(OP_J, 5'd1, 5'd1, 16'h1);
      #1;
      total++; if (out_valid !== 1 || in_ready !== 0 || x_out !== 32'h100 || y_out !== 32'hFFFFFFF0) begin
        bad++; $display("FAIL lw_hold%0d ov=%b ir=%b x=%h y=%h want ov=1 ir=0 x=100 y=fffffff0", i, out_valid, in_ready, x_out, y_out);
      end
      tick();
    end
    exp_x = 32'h100; exp_y = 32'hFFFFFFF0;
    in_valid = 0; out_ready = 1; tick(); out_ready = 0;
    total++; if (out_valid !== 0) begin bad++; $display("FAIL lw_release ov got=%b want=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1; out_ready = 1; ir_in = mk(OP_J, 5'd0, 5'd0, 16'h3); pc_in = 30'h200;
    #1;
    total++; if (in_ready !== 1) begin bad++; $display("FAIL b2b_first_ready got=%b want=1", in_ready); end
    tick();
    exp_x = 32'h3;
    total++; if (out_valid !== 1 || x_out !== 32'h3 || ir_out !== mk(OP_J, 5'd0, 5'd0, 16'h3) || rd1_en || rd2_en) begin
      bad++; $display("FAIL b2b_jump ov=%b x=%h ir=%h en=%b%b want ov=1 x=3 en=00", out_valid, x_out, ir_out, rd1_en, rd2_en);
    end
    ir_in = NOP_IR; pc_in = 30'h201;
    #1;
    total++; if (in_ready !== 1) begin bad++; $display("FAIL b2b_second_ready got=%b want=1", in_ready); end
    tick();
    total++; if (out_valid !== 1 || x_out !== exp_x || y_out !== exp_y || ir_out !== NOP_IR || pc_out !== 30'h201 || rd1_en || rd2_en) begin
      bad++; $display("FAIL b2b_nop ov=%b x=%h y=%h ir=%h pc=%h en=%b%b want ov=1 x=%h y=%h ir=0 pc=201 en=00",
                      out_valid, x_out, y_out, ir_out, pc_out, rd1_en, rd2_en, exp_x, exp_y);
    end
    in_valid = 0;
    tick();
    out_ready = 0;
    total++; if (out_valid !== 0) begin bad++; $display("FAIL b2b_drain ov got=%b want=0", out_valid); end
  endtask

  task automatic test_flush();
    in_valid = 1; ir_in = mk(OP_R, 5'd0, 5'd7, {5'd8, 11'd0}); pc_in = 30'h300;
    tick();
    in_valid = 0;
    rd1_st = 1; rd1_data = 32'h77;
    tick();
    rd1_st = 0;
    exp_x = 32'h77;
    total++; if (rd1_en !== 0 || rd2_en !== 1) begin bad++; $display("FAIL flush_pre en=%b%b want en=01", rd1_en, rd2_en); end
    flush = 1; in_valid = 1; ir_in = mk(OP_J, 5'd2, 5'd2, 16'h2);
    #1;
    total++; if (in_ready !== 0) begin bad++; $display("FAIL flush_in_ready got=%b want=0", in_ready); end
    tick();
    flush = 0; in_valid = 0;
    total++; if (out_valid !== 0 || rd1_en !== 0 || rd2_en !== 0 || ir_out !== NOP_IR) begin
      bad++; $display("FAIL flush_state ov=%b en=%b%b ir=%h want ov=0 en=00 ir=0", out_valid, rd1_en, rd2_en, ir_out);
    end
    rd2_st = 1; rd2_data = 32'hDEAD;
    tick(); tick();
    rd2_st = 0;
    total++; if (out_valid !== 0 || rd2_en !== 0 || y_out !== exp_y || x_out !== exp_x || in_ready !== 1) begin
      bad++; $display("FAIL flush_late_strobe ov=%b en2=%b x=%h y=%h ir=%b want ov=0 en2=0 x=%h y=%h ir=1",
                      out_valid, rd2_en, x_out, y_out, in_ready, exp_x, exp_y);
    end
  endtask

  task automatic test_reset_mid_req();
    in_valid = 1; ir_in = mk(OP_R, 5'd0, 5'd1, {5'd2, 11'd0}); pc_in = 30'h400;
    tick();
    in_valid = 0;
    total++; if (rd1_en !== 1) begin bad++; $display("FAIL rstreq_pre en1 got=%b want=1", rd1_en); end
    #1 rst = 1;
    #1;
    total++; if (rd1_en !== 0 || rd2_en !== 0 || out_valid !== 0 || ir_out !== NOP_IR || x_out !== 0) begin
      bad++; $display("FAIL rstreq_async en=%b%b ov=%b ir=%h x=%h want en=00 ov=0 ir=0 x=0", rd1_en, rd2_en, out_valid, ir_out, x_out);
    end
    tick();
    rst = 0;
    exp_x = '0; exp_y = '0;
    run_txn(mk(OP_LW, 5'd0, 5'd6, 16'h0040), 30'h404, 1);
  endtask

`ifdef ID_FORWARD_EN
  task automatic test_forward();
    in_valid = 1; ir_in = mk(OP_R, 5'd0, 5'd5, {5'd6, 11'd0}); pc_in = 30'h500;
    tick();
    in_valid = 0;
    rd1_st = 1; rd1_data = 32'h55; rd2_st = 1; rd2_data = 32'h66;
    wb_en = 1; wb_addr = 5'd5; wb_data = 32'hAA;
    tick();
    rd1_st = 0; rd2_st = 0; wb_en = 0;
    total++; if (out_valid !== 1 || x_out !== 32'hAA || y_out !== 32'h66) begin
      bad++; $display("FAIL forward ov=%b x=%h y=%h want ov=1 x=aa y=66", out_valid, x_out, y_out);
    end
    exp_x = 32'hAA; exp_y = 32'h66;
    out_ready = 1; tick(); out_ready = 0;
  endtask
`endif

  task automatic test_random();
    logic [5:0] ops [13];
    logic [5:0] op;
    ops = '{OP_NOP, OP_R, OP_I, OP_LW, OP_LH, OP_LD, OP_BR, OP_SD, OP_SH, OP_SW, OP_J, OP_HALT, OP_UND};
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 12)];
      run_txn({op, 26'($urandom)}, 30'($urandom), $urandom_range(0, 2));
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) regs[r] = $urandom;
    test_reset();
    test_rtype_latency();
    test_lw_hold();
    test_back_to_back();
    test_flush();
    test_reset_mid_req();
`ifdef ID_FORWARD_EN
    test_forward();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
